// File: rtl/rob_pkg.sv
// Shared types and constants for the parametrised reorder buffer.
package rob_pkg;
  // Storage widths are fixed at the maxima; the ROB only uses the low DATA_W/AREG_W bits.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_AREG_W = 8;

  localparam int BR_OK   = 1;
  localparam int BR_MISS = 2;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  exc;
    logic                  is_br;
    logic [MAX_AREG_W-1:0] dest;
    logic [MAX_DATA_W-1:0] value;
  } rob_entry_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/rob_commit_scan.sv
// In-order commit/flush selection over a COMMIT_W window starting at head.
module rob_commit_scan
  import rob_pkg::*;
#(
  parameter int COMMIT_W = 2,
  parameter int CNT_W    = cnt_w(COMMIT_W)
) (
  input  logic [COMMIT_W-1:0] i_busy,
  input  logic [COMMIT_W-1:0] i_done,
  input  logic [COMMIT_W-1:0] i_exc,
  output logic [COMMIT_W-1:0] o_commit,
  output logic [CNT_W-1:0]    o_ncommit,
  output logic                o_flush
);
  logic w_run;

  // A slot commits only if every older slot in the window also commits.
  always_comb begin
    w_run     = 1'b1;
    o_commit  = '0;
    o_ncommit = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      w_run       = w_run & i_busy[k] & i_done[k] & ~i_exc[k];
      o_commit[k] = w_run;
      if (w_run) o_ncommit = o_ncommit + CNT_W'(1);
    end
  end

  assign o_flush = i_busy[0] & i_done[0] & i_exc[0];
endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, out-of-order complete, in-order commit, flush on mispredict at head.
module rob_param
  import rob_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int DISP_W   = 2,
  parameter int NUM_CDB  = 2,
  parameter int COMMIT_W = 2,
  parameter int DATA_W   = 32,
  parameter int AREG_W   = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DISP_W-1:0]                     disp_valid,
  input  logic [DISP_W-1:0]                     disp_is_br,
  input  logic [DISP_W*AREG_W-1:0]              disp_dest,
  output logic                                  disp_ready,
  output logic [DISP_W*$clog2(DEPTH)-1:0]       disp_tag,
  input  logic [NUM_CDB-1:0]                    cdb_valid,
  input  logic [NUM_CDB*$clog2(DEPTH)-1:0]      cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]             cdb_value,
  input  logic                                  br_valid,
  input  logic [$clog2(DEPTH)-1:0]              br_tag,
  input  logic                                  br_mispredict,
  output logic [COMMIT_W-1:0]                   commit_valid,
  output logic [COMMIT_W*$clog2(DEPTH)-1:0]     commit_tag,
  output logic [COMMIT_W*AREG_W-1:0]            commit_dest,
  output logic [COMMIT_W*DATA_W-1:0]            commit_value,
  output logic                                  flush,
  output logic [$clog2(DEPTH)-1:0]              flush_tag,
  output logic [$clog2(DEPTH):0]                count,
  output logic                                  empty,
  output logic                                  full
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(COMMIT_W);

  typedef logic [TAG_W:0]   ptr_t;
  typedef logic [TAG_W-1:0] tag_t;

  rob_entry_t                  r_ent [DEPTH];
  ptr_t                        r_head, r_tail;
  logic [COMMIT_W-1:0]         r_cv;
  logic [COMMIT_W*TAG_W-1:0]   r_ctag;
  logic [COMMIT_W*AREG_W-1:0]  r_cdest;
  logic [COMMIT_W*DATA_W-1:0]  r_cval;
  logic                        r_flush;
  tag_t                        r_flush_tag;

  ptr_t                w_count, w_free, w_ndisp;
  logic                w_acc, w_flush;
  logic [DISP_W-1:0]   w_dv_inc;
  tag_t                w_win_idx  [COMMIT_W];
  tag_t                w_disp_idx [DISP_W];
  logic [COMMIT_W-1:0] w_wbusy, w_wdone, w_wexc, w_commit;
  logic [CNT_W-1:0]    w_ncommit;

  assign w_count    = r_tail - r_head;
  assign w_free     = ptr_t'(DEPTH) - w_count;
  assign disp_ready = (w_free >= ptr_t'(DISP_W)) && !w_flush;
  assign w_acc      = disp_ready && disp_valid[0];
  assign w_dv_inc   = disp_valid + DISP_W'(1);

  always_comb begin
    w_ndisp  = '0;
    disp_tag = '0;
    for (int k = 0; k < DISP_W; k++) begin
      w_disp_idx[k]               = r_tail[TAG_W-1:0] + tag_t'(k);
      disp_tag[k*TAG_W +: TAG_W]  = w_disp_idx[k];
      if (disp_valid[k]) w_ndisp  = w_ndisp + ptr_t'(1);
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      w_win_idx[k] = r_head[TAG_W-1:0] + tag_t'(k);
      w_wbusy[k]   = r_ent[w_win_idx[k]].busy;
      w_wdone[k]   = r_ent[w_win_idx[k]].done;
      w_wexc[k]    = r_ent[w_win_idx[k]].exc;
    end
  end

  rob_commit_scan #(.COMMIT_W(COMMIT_W), .CNT_W(CNT_W)) u_scan (
    .i_busy    (w_wbusy),
    .i_done    (w_wdone),
    .i_exc     (w_wexc),
    .o_commit  (w_commit),
    .o_ncommit (w_ncommit),
    .o_flush   (w_flush)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_cv        <= '0;
      r_ctag      <= '0;
      r_cdest     <= '0;
      r_cval      <= '0;
      r_flush     <= 1'b0;
      r_flush_tag <= '0;
    end else if (w_flush) begin
      // Mispredicted branch at head: retire it and drop everything younger.
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head      <= r_head + ptr_t'(1);
      r_tail      <= r_head + ptr_t'(1);
      r_cv        <= '0;
      r_flush     <= 1'b1;
      r_flush_tag <= r_head[TAG_W-1:0];
    end else begin
      r_flush <= 1'b0;
      r_cv    <= w_commit;
      for (int k = 0; k < COMMIT_W; k++) begin
        r_ctag [k*TAG_W  +: TAG_W]  <= w_win_idx[k];
        r_cdest[k*AREG_W +: AREG_W] <= r_ent[w_win_idx[k]].dest[AREG_W-1:0];
        r_cval [k*DATA_W +: DATA_W] <= r_ent[w_win_idx[k]].value[DATA_W-1:0];
      end
      // Descending order so the lowest-index bus lands last and wins.
      for (int i = NUM_CDB-1; i >= 0; i--) begin
        if (cdb_valid[i] && r_ent[cdb_tag[i*TAG_W +: TAG_W]].busy) begin
          r_ent[cdb_tag[i*TAG_W +: TAG_W]].done  <= 1'b1;
          r_ent[cdb_tag[i*TAG_W +: TAG_W]].value <= MAX_DATA_W'(cdb_value[i*DATA_W +: DATA_W]);
        end
      end
      if (br_valid && r_ent[br_tag].busy) begin
        r_ent[br_tag].done  <= 1'b1;
        r_ent[br_tag].exc   <= br_mispredict;
        r_ent[br_tag].value <= MAX_DATA_W'(br_mispredict ? BR_MISS : BR_OK);
      end
      for (int k = 0; k < COMMIT_W; k++)
        if (w_commit[k]) r_ent[w_win_idx[k]] <= '0;
      if (w_acc) begin
        for (int k = 0; k < DISP_W; k++)
          if (disp_valid[k])
            r_ent[w_disp_idx[k]] <= '{busy: 1'b1, done: 1'b0, exc: 1'b0, is_br: disp_is_br[k],
                                      dest: MAX_AREG_W'(disp_dest[k*AREG_W +: AREG_W]), value: '0};
      end
      r_head <= r_head + ptr_t'(w_ncommit);
      r_tail <= r_tail + (w_acc ? w_ndisp : ptr_t'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert ((w_dv_inc & disp_valid) == '0);
      for (int i = 0; i < NUM_CDB; i++)
        for (int j = i + 1; j < NUM_CDB; j++)
          assert (!(cdb_valid[i] && cdb_valid[j] &&
                    cdb_tag[i*TAG_W +: TAG_W] == cdb_tag[j*TAG_W +: TAG_W]));
      assert (!br_valid || !r_ent[br_tag].busy || r_ent[br_tag].is_br);
    end
  end

  assign commit_valid = r_cv;
  assign commit_tag   = r_ctag;
  assign commit_dest  = r_cdest;
  assign commit_value = r_cval;
  assign flush        = r_flush;
  assign flush_tag    = r_flush_tag;
  assign count        = w_count;
  assign empty        = (r_head == r_tail);
  assign full         = (r_head[TAG_W] != r_tail[TAG_W]) &&
                        (r_head[TAG_W-1:0] == r_tail[TAG_W-1:0]);
endmodule

// File: tb/tb_rob_param.sv
// Scoreboard bench for rob_param: stimulus pushes expected commits/flushes, a monitor pops and compares.
module tb_rob_param;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  disp_valid, disp_is_br;
  logic [5:0]  disp_dest;
  logic        disp_ready;
  logic [5:0]  disp_tag;
  logic [1:0]  cdb_valid;
  logic [5:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic        br_valid;
  logic [2:0]  br_tag;
  logic        br_mispredict;
  logic [1:0]  commit_valid;
  logic [5:0]  commit_tag;
  logic [5:0]  commit_dest;
  logic [63:0] commit_value;
  logic        flush;
  logic [2:0]  flush_tag;
  logic [3:0]  count;
  logic        empty, full;

  rob_param dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_is_br(disp_is_br), .disp_dest(disp_dest),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .br_valid(br_valid), .br_tag(br_tag), .br_mispredict(br_mispredict),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_dest(commit_dest),
    .commit_value(commit_value), .flush(flush), .flush_tag(flush_tag),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct { int tag; int dest; int val; } exp_t;
  exp_t cq[$];
  int   fq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_c(input int tag, input int dest, input int val);
    exp_t e;
    e.tag = tag; e.dest = dest; e.val = val;
    cq.push_back(e);
  endtask

  task automatic clr();
    disp_valid = '0; disp_is_br = '0; disp_dest = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    br_valid = 1'b0; br_tag = '0; br_mispredict = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1; clr();
  endtask

  task automatic disp(input logic [1:0] v, input logic [1:0] br, input int d0, input int d1);
    disp_valid = v; disp_is_br = br;
    disp_dest = {3'(d1), 3'(d0)};
  endtask

  task automatic cdb(input int bus, input int tag, input int val);
    cdb_valid[bus] = 1'b1;
    cdb_tag[bus*3 +: 3] = 3'(tag);
    cdb_value[bus*32 +: 32] = 32'(val);
  endtask

  // Monitor: every commit slot and flush pulse must match the next expectation.
  always @(negedge clk) begin
    if (flush) begin
      chk("flush_expected", fq.size() > 0, 1);
      if (fq.size() > 0) chk("flush_tag", flush_tag, fq.pop_front());
      chk("flush_no_commit", commit_valid, 0);
    end
    for (int k = 0; k < 2; k++) begin
      if (commit_valid[k]) begin
        if (cq.size() == 0) chk("commit_unexpected_tag", commit_tag[k*3 +: 3], -1);
        else begin
          exp_t e;
          e = cq.pop_front();
          chk("commit_tag",   commit_tag[k*3 +: 3],    e.tag);
          chk("commit_dest",  commit_dest[k*3 +: 3],   e.dest);
          chk("commit_value", commit_value[k*32 +: 32], e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr();
    reset = 1'b0;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_flush_tag", flush_tag, 0);
    chk("rst_disp_ready", disp_ready, 1);
    reset = 1'b1;

    // Basic dispatch, out-of-order completion, dual commit
    disp(2'b11, 2'b00, 3, 5);
    chk("t1_disp_tag", disp_tag, 6'b001_000);
    push_c(0, 3, 9); push_c(1, 5, 7);
    tick();
    chk("t1_count", count, 2);
    cdb(0, 1, 7); tick();
    cdb(0, 0, 9); tick();
    chk("t1_count_pre_commit", count, 2);
    tick();
    chk("t1_commit_valid", commit_valid, 2'b11);
    chk("t1_empty", empty, 1);
    chk("t1_count_post", count, 0);

    // Restart from tag 0 and fill; entry 2 is a branch
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      disp(2'b11, (i == 1) ? 2'b01 : 2'b00, 2*i, 2*i + 1);
      chk("fill_disp_tag", disp_tag[2:0], 2*i);
      tick();
    end
    chk("fill_count", count, 8);
    chk("fill_full", full, 1);
    chk("fill_disp_ready", disp_ready, 0);
    disp(2'b11, 2'b00, 1, 1); tick();
    chk("fill_ignored_count", count, 8);
    chk("fill_ignored_tag", disp_tag, 6'b001_000);

    // Wrap: commit tags 0/1, reuse them
    cdb(0, 0, 100); cdb(1, 1, 101);
    push_c(0, 0, 100); push_c(1, 1, 101);
    tick();
    chk("wrap_no_bypass_ready", disp_ready, 0);
    tick();
    chk("wrap_commit_valid", commit_valid, 2'b11);
    chk("wrap_count_freed", count, 6);
    chk("wrap_disp_ready", disp_ready, 1);
    chk("wrap_disp_tag", disp_tag, 6'b001_000);
    disp(2'b11, 2'b00, 4, 6); tick();
    chk("wrap_count", count, 8);
    chk("wrap_tail_low", disp_tag[2:0], 2);

    // Mispredict at head tag 2 with younger 3..5 done
    cdb(0, 3, 33); cdb(1, 4, 44); tick();
    cdb(0, 5, 55); tick();
    br_valid = 1'b1; br_tag = 3'd2; br_mispredict = 1'b1;
    fq.push_back(2);
    tick();
    chk("br_pending_ready", disp_ready, 0);
    chk("br_pending_commit", commit_valid, 0);
    tick();
    chk("br_flush", flush, 1);
    chk("br_flush_tag", flush_tag, 2);
    chk("br_count", count, 0);
    chk("br_next_tag", disp_tag[2:0], 3);
    chk("br_ready_after", disp_ready, 1);
    tick();
    chk("br_flush_pulse", flush, 0);

    // Correct branch: br beats same-cycle cdb; cdb to free slot dropped
    disp(2'b01, 2'b01, 2, 0); tick();
    br_valid = 1'b1; br_tag = 3'd3; br_mispredict = 1'b0;
    cdb(0, 3, 'h99); cdb(1, 7, 'hdead);
    push_c(3, 2, 1);
    tick(); tick();
    chk("brok_commit_valid", commit_valid, 2'b01);

    // Simultaneous completion of head pair 4/5
    disp(2'b11, 2'b00, 6, 7);
    push_c(4, 6, 'h44); push_c(5, 7, 'h55);
    tick();
    cdb(0, 4, 'h44); cdb(1, 5, 'h55); tick();
    tick();
    chk("dual_commit_valid", commit_valid, 2'b11);
    chk("dual_count", count, 0);

    // Pending flush alone blocks dispatch even with free space
    disp(2'b01, 2'b01, 1, 0); tick();
    br_valid = 1'b1; br_tag = 3'd6; br_mispredict = 1'b1;
    fq.push_back(6);
    tick();
    chk("fp_ready", disp_ready, 0);
    chk("fp_count", count, 1);
    disp(2'b01, 2'b00, 5, 0);
    tick();
    chk("fp_flush", flush, 1);
    chk("fp_count_after", count, 0);
    chk("fp_next_tag", disp_tag[2:0], 7);

    // Mid-stream reset with five done entries behind a blocked head
    disp(2'b11, 2'b00, 1, 2); tick();
    disp(2'b11, 2'b00, 3, 4); tick();
    disp(2'b11, 2'b00, 5, 6); tick();
    cdb(0, 0, 10); cdb(1, 1, 11); tick();
    cdb(0, 2, 12); cdb(1, 3, 13); tick();
    cdb(0, 4, 14); tick();
    chk("mid_count", count, 6);
    reset = 1'b0; tick();
    chk("mid_commit_valid", commit_valid, 0);
    chk("mid_flush", flush, 0);
    chk("mid_count_rst", count, 0);
    chk("mid_disp_tag", disp_tag[2:0], 0);
    reset = 1'b1;
    tick(); tick();
    chk("mid_quiet_commit", commit_valid, 0);

    chk("sb_commit_drain", cq.size(), 0);
    chk("sb_flush_drain", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
